// File: rtl/dpll_pkg.sv
// Shared types and defaults for the DPSK bit-clock DPLL
// (phase detector, loop filter and DCO).
package dpll_pkg;

  // Loop filter sequencing states
  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    FIRE  = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Correction direction; UP inserts a DCO step, DN removes one
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Loop defaults agreed between the phase detector, loop filter and DCO
  localparam int DEFAULT_K_MOD   = 8;
  localparam int DEFAULT_HOLDOFF = 4;

endpackage

// File: rtl/dpll_lock_det.sv
// Lock detector for the DPLL loop filter: counts correction-free cycles,
// saturating at LOCK_CYCLES, and flags lock once the count is reached.
module dpll_lock_det #(
  parameter int LOCK_CYCLES = 1024,
  parameter int LOCK_W      = 11
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sclr,
  input  logic enter_fire,
  input  logic in_fire,
  output logic locked
);

  localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_CYCLES);

  logic [LOCK_W-1:0] cnt_q;
  logic [LOCK_W-1:0] cnt_d;

  // Next count: cleared by a correction, held during FIRE, otherwise saturating increment
  always_comb begin
    cnt_d = cnt_q;
    if (sclr || enter_fire) begin
      cnt_d = '0;
    end else if (!in_fire && (cnt_q != LOCK_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter and registered lock flag, both following the next count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      locked <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      locked <= (cnt_d == LOCK_MAX);
    end
  end

endmodule

// File: rtl/dpll_loop_filter.sv
// Random-walk (K-modulus up/down) loop filter for the 50 kHz DPSK bit-clock DPLL.
// Integrates lag/lead pulses from the phase detector and issues one-cycle
// add/deduct corrections to the DCO, followed by a hold-off window.
// Optional lock detection is built when DPLL_LOCK_DET_EN is defined;
// otherwise locked is tied low.
module dpll_loop_filter
  import dpll_pkg::*;
#(
  parameter int K_MOD       = DEFAULT_K_MOD,
  parameter int CNT_W       = 5,
  parameter int HOLDOFF     = DEFAULT_HOLDOFF,
  parameter int LOCK_CYCLES = 1024,
  parameter int LOCK_W      = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sclr,
  input  logic             lag_pulse,
  input  logic             lead_pulse,
  output logic             add_pulse,
  output logic             deduct_pulse,
  output logic [CNT_W-1:0] acc_o,
  output logic             locked
);

  localparam int HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST =
    (HOLDOFF > 0) ? HOLD_W'(HOLDOFF - 1) : '0;
  localparam logic signed [CNT_W-1:0] K_POS = CNT_W'(K_MOD);
  localparam logic signed [CNT_W-1:0] K_NEG = CNT_W'(-K_MOD);

  // The accumulator must hold +/-K_MOD and the lock counter must hold LOCK_CYCLES
  if ((2 ** (CNT_W - 1)) <= K_MOD) begin : g_bad_cnt_w
    $error("dpll_loop_filter: CNT_W too small for K_MOD");
  end
  if (LOCK_W < $clog2(LOCK_CYCLES + 1)) begin : g_bad_lock_w
    $error("dpll_loop_filter: LOCK_W too small for LOCK_CYCLES");
  end

  state_t                   state_q;
  state_t                   state_d;
  logic signed [CNT_W-1:0]  acc_q;
  logic signed [CNT_W-1:0]  acc_d;
  logic signed [CNT_W-1:0]  acc_n;
  logic signed [CNT_W-1:0]  delta;
  logic                     dir_q;
  logic                     dir_d;
  logic [HOLD_W-1:0]        hold_q;
  logic [HOLD_W-1:0]        hold_d;

  // Phase error step for this cycle; simultaneous lag and lead cancel out
  always_comb begin
    delta = '0;
    case ({lag_pulse, lead_pulse})
      2'b10:   delta = CNT_W'(1);
      2'b01:   delta = '1;
      default: delta = '0;
    endcase
  end

  assign acc_n = acc_q + delta;

  // Next-state logic: accumulate, fire on reaching +/-K_MOD, then sit out the hold-off
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    dir_d   = dir_q;
    hold_d  = hold_q;
    if (sclr) begin
      state_d = ACCUM;
      acc_d   = '0;
      dir_d   = DIR_UP;
      hold_d  = '0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (acc_n == K_POS) begin
            acc_d   = '0;
            dir_d   = DIR_UP;
            state_d = FIRE;
          end else if (acc_n == K_NEG) begin
            acc_d   = '0;
            dir_d   = DIR_DN;
            state_d = FIRE;
          end else begin
            acc_d = acc_n;
          end
        end
        FIRE: begin
          hold_d  = '0;
          state_d = (HOLDOFF > 0) ? HOLD : ACCUM;
        end
        HOLD: begin
          if (hold_q == HOLD_LAST) begin
            hold_d  = '0;
            state_d = ACCUM;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
        default: begin
          state_d = ACCUM;
          acc_d   = '0;
          hold_d  = '0;
        end
      endcase
    end
  end

  // State, accumulator, direction and hold-off registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      dir_q   <= DIR_UP;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      dir_q   <= dir_d;
      hold_q  <= hold_d;
    end
  end

  assign add_pulse    = (state_q == FIRE) && (dir_q == DIR_UP);
  assign deduct_pulse = (state_q == FIRE) && (dir_q == DIR_DN);
  assign acc_o        = acc_q;

`ifdef DPLL_LOCK_DET_EN
  dpll_lock_det #(
    .LOCK_CYCLES (LOCK_CYCLES),
    .LOCK_W      (LOCK_W)
  ) u_lock_det (
    .clk        (clk),
    .rst_n      (rst_n),
    .sclr       (sclr),
    .enter_fire (state_d == FIRE),
    .in_fire    (state_q == FIRE),
    .locked     (locked)
  );
`else
  assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_dpll_loop_filter.sv
// Self-checking bench for dpll_loop_filter. A cycle-level reference model
// pushes the expected outputs for each driven cycle into a scoreboard queue;
// each test task pops and compares them after the clock edge.
// Works with or without DPLL_LOCK_DET_EN defined.
module tb_dpll_loop_filter;

  localparam int K_MOD       = 8;
  localparam int CNT_W       = 5;
  localparam int HOLDOFF     = 4;
  localparam int LOCK_CYCLES = 16;
  localparam int LOCK_W      = 5;

  logic             clk;
  logic             rst_n;
  logic             sclr;
  logic             lag_pulse;
  logic             lead_pulse;
  logic             add_pulse;
  logic             deduct_pulse;
  logic [CNT_W-1:0] acc_o;
  logic             locked;

  typedef struct packed {
    logic             add;
    logic             ded;
    logic [CNT_W-1:0] acc;
    logic             lk;
  } obs_t;

  obs_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model state
  int m_acc;
  int m_fire;
  int m_hold;
  int m_lock;

  dpll_loop_filter #(
    .K_MOD       (K_MOD),
    .CNT_W       (CNT_W),
    .HOLDOFF     (HOLDOFF),
    .LOCK_CYCLES (LOCK_CYCLES),
    .LOCK_W      (LOCK_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sclr         (sclr),
    .lag_pulse    (lag_pulse),
    .lead_pulse   (lead_pulse),
    .add_pulse    (add_pulse),
    .deduct_pulse (deduct_pulse),
    .acc_o        (acc_o),
    .locked       (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic obs_t observe();
    obs_t o;
    o.add = add_pulse;
    o.ded = deduct_pulse;
    o.acc = acc_o;
    o.lk  = locked;
    return o;
  endfunction

  function automatic void model_reset();
    m_acc  = 0;
    m_fire = 0;
    m_hold = 0;
    m_lock = 0;
  endfunction

  function automatic void lock_tick();
    if (m_lock < LOCK_CYCLES) m_lock = m_lock + 1;
  endfunction

  function automatic void model_step(input logic lg, input logic ld, input logic clr);
    if (clr) begin
      model_reset();
    end else if (m_fire != 0) begin
      m_fire = 0;
      m_hold = HOLDOFF;
    end else if (m_hold > 0) begin
      m_hold = m_hold - 1;
      lock_tick();
    end else begin
      m_acc = m_acc + int'(lg) - int'(ld);
      if (m_acc == K_MOD) begin
        m_acc = 0; m_fire = 1; m_lock = 0;
      end else if (m_acc == -K_MOD) begin
        m_acc = 0; m_fire = -1; m_lock = 0;
      end else begin
        lock_tick();
      end
    end
  endfunction

  function automatic obs_t model_out();
    obs_t o;
    o.add = (m_fire == 1);
    o.ded = (m_fire == -1);
    o.acc = CNT_W'(m_acc);
`ifdef DPLL_LOCK_DET_EN
    o.lk  = (m_lock == LOCK_CYCLES);
`else
    o.lk  = 1'b0;
`endif
    return o;
  endfunction

  // Drive one cycle of stimulus, record the model's expectation, advance past the edge
  task automatic drive_cycle(input logic lg, input logic ld, input logic clr);
    lag_pulse  = lg;
    lead_pulse = ld;
    sclr       = clr;
    model_step(lg, ld, clr);
    exp_q.push_back(model_out());
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t got;
    rst_n = 1'b0; sclr = 1'b0; lag_pulse = 1'b0; lead_pulse = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    got = observe();
    checks++;
    if (got !== obs_t'(0)) begin
      failures++;
      $display("[TB] FAIL reset_state: got %h required %h", got, obs_t'(0));
    end
    rst_n = 1'b1;
  endtask

  task automatic test_lag_fire();
    obs_t got, e;
    for (int i = 0; i < K_MOD + 2; i++) begin
      drive_cycle(i < K_MOD, 1'b0, 1'b0);
      e = exp_q.pop_front(); got = observe();
      checks++;
      if (got !== e) begin
        failures++;
        $display("[TB] FAIL lag_fire cyc%0d: got %h required %h", i, got, e);
      end
    end
    for (int i = 0; i < HOLDOFF; i++) begin
      drive_cycle(1'b0, 1'b0, 1'b0);
      e = exp_q.pop_front(); got = observe();
      checks++;
      if (got !== e) begin
        failures++;
        $display("[TB] FAIL lag_settle cyc%0d: got %h required %h", i, got, e);
      end
    end
  endtask

  task automatic test_lead_fire();
    obs_t got, e;
    for (int i = 0; i < K_MOD; i++) begin
      drive_cycle(1'b0, 1'b1, 1'b0);
      e = exp_q.pop_front(); got = observe();
      checks++;
      if (got !== e) begin
        failures++;
        $display("[TB] FAIL lead_fire cyc%0d: got %h required %h", i, got, e);
      end
    end
    checks++;
    if (deduct_pulse !== 1'b1 || add_pulse !== 1'b0) begin
      failures++;
      $display("[TB] FAIL lead_deduct: got add=%0b ded=%0b required add=0 ded=1",
               add_pulse, deduct_pulse);
    end
    for (int i = 0; i < HOLDOFF + 1; i++) begin
      drive_cycle(1'b0, 1'b0, 1'b0);
      e = exp_q.pop_front(); got = observe();
      checks++;
      if (got !== e) begin
        failures++;
        $display("[TB] FAIL lead_settle cyc%0d: got %h required %h", i, got, e);
      end
    end
  endtask

  task automatic test_alternate_both();
    obs_t got, e;
    for (int i = 0; i < 120; i++) begin
      if (i < 100) drive_cycle(i % 2 == 0, i % 2 == 1, 1'b0);
      else         drive_cycle(1'b1, 1'b1, 1'b0);
      e = exp_q.pop_front(); got = observe();
      checks++;
      if (got !== e) begin
        failures++;
        $display("[TB] FAIL alt_both cyc%0d: got %h required %h", i, got, e);
      end
    end
  endtask

  task automatic test_holdoff();
    obs_t got, e;
    for (int i = 0; i < K_MOD + 1 + HOLDOFF + 1; i++) begin
      drive_cycle(1'b1, 1'b0, 1'b0);
      e = exp_q.pop_front(); got = observe();
      checks++;
      if (got !== e) begin
        failures++;
        $display("[TB] FAIL holdoff cyc%0d: got %h required %h", i, got, e);
      end
    end
    checks++;
    if (acc_o !== CNT_W'(1)) begin
      failures++;
      $display("[TB] FAIL holdoff_acc: got %0d required 1", acc_o);
    end
    drive_cycle(1'b0, 1'b0, 1'b1);
    e = exp_q.pop_front(); got = observe();
    checks++;
    if (got !== e) begin
      failures++;
      $display("[TB] FAIL holdoff_clr: got %h required %h", got, e);
    end
  endtask

  task automatic test_sclr_async_reset();
    obs_t got, e;
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1'b1, 1'b0, 1'b0);
      void'(exp_q.pop_front());
    end
    checks++;
    if (acc_o !== CNT_W'(5)) begin
      failures++;
      $display("[TB] FAIL pre_sclr_acc: got %0d required 5", acc_o);
    end
    drive_cycle(1'b1, 1'b0, 1'b1);
    e = exp_q.pop_front(); got = observe();
    checks++;
    if (got !== e) begin
      failures++;
      $display("[TB] FAIL sclr: got %h required %h", got, e);
    end
    // Fire, then stop two cycles later while sitting in HOLD
    for (int i = 0; i < K_MOD + 2; i++) begin
      drive_cycle(i < K_MOD, 1'b0, 1'b0);
      void'(exp_q.pop_front());
    end
    lag_pulse = 1'b0;
    rst_n = 1'b0;
    #2;
    model_reset();
    got = observe();
    checks++;
    if (got !== obs_t'(0)) begin
      failures++;
      $display("[TB] FAIL async_reset: got %h required %h", got, obs_t'(0));
    end
    rst_n = 1'b1;
    for (int i = 0; i < K_MOD + 1; i++) begin
      drive_cycle(i < K_MOD, 1'b0, 1'b0);
      e = exp_q.pop_front(); got = observe();
      checks++;
      if (got !== e) begin
        failures++;
        $display("[TB] FAIL post_reset cyc%0d: got %h required %h", i, got, e);
      end
    end
  endtask

  task automatic test_lock();
    obs_t got, e;
    logic exp_lk;
    drive_cycle(1'b0, 1'b0, 1'b1);
    void'(exp_q.pop_front());
    for (int i = 0; i < LOCK_CYCLES; i++) begin
      drive_cycle(1'b0, 1'b0, 1'b0);
      e = exp_q.pop_front(); got = observe();
      checks++;
      if (got !== e) begin
        failures++;
        $display("[TB] FAIL lock_idle cyc%0d: got %h required %h", i, got, e);
      end
    end
`ifdef DPLL_LOCK_DET_EN
    exp_lk = 1'b1;
`else
    exp_lk = 1'b0;
`endif
    checks++;
    if (locked !== exp_lk) begin
      failures++;
      $display("[TB] FAIL lock_set: got %0b required %0b", locked, exp_lk);
    end
    for (int i = 0; i < K_MOD; i++) begin
      drive_cycle(1'b1, 1'b0, 1'b0);
      void'(exp_q.pop_front());
    end
    checks++;
    if (locked !== 1'b0 || add_pulse !== 1'b1) begin
      failures++;
      $display("[TB] FAIL lock_fire: got locked=%0b add=%0b required locked=0 add=1",
               locked, add_pulse);
    end
    for (int i = 0; i < LOCK_CYCLES + 1; i++) begin
      drive_cycle(1'b0, 1'b0, 1'b0);
      e = exp_q.pop_front(); got = observe();
      checks++;
      if (got !== e) begin
        failures++;
        $display("[TB] FAIL relock cyc%0d: got %h required %h", i, got, e);
      end
    end
    checks++;
    if (locked !== exp_lk) begin
      failures++;
      $display("[TB] FAIL relock_final: got %0b required %0b", locked, exp_lk);
    end
  endtask

  initial begin
    test_reset();
    test_lag_fire();
    test_lead_fire();
    test_alternate_both();
    test_holdoff();
    test_sclr_async_reset();
    test_lock();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
